pic_ctrl: RTL and testbench

- Parametrised programmable interrupt controller in front of the `cpu` core.
- Replaces the single hard-wired `intr`/`vector` pair driven by the bench with NSRC prioritised, maskable request lines.
- Presents one request at a time on `intr`/`vector` and runs the request/acknowledge/end-of-interrupt handshake with the core's `inta`.

---
 rtl/pic_ctrl.sv | 118 +++++++++++
 tb/tb_pic_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ctrl.sv
// pic_ctrl: prioritised, maskable interrupt controller presenting one request at a time
// on intr/vector with an inta/eoi handshake. Define PIC_LEVEL_EN for level-sensitive irq.
module pic_ctrl #(
    parameter int               NSRC     = 8,
    parameter int               VEC_W    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(8'h50),
    localparam int              ID_W     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [NSRC-1:0]  irq,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_wdata,
    output logic [NSRC-1:0]  mask,
    output logic             intr,
    output logic [VEC_W-1:0] vector,
    input  logic             inta,
    input  logic             eoi,
    output logic             in_service,
    output logic [ID_W-1:0]  isr_id
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_n;
    logic [NSRC-1:0]    pending, elig;
    logic [ID_W-1:0]    win, isr_id_n;
    logic               win_vld, withdraw;
    logic               intr_n, in_service_n;
    logic [VEC_W-1:0]   vector_n;

    assign elig    = pending & ~mask;
    assign win_vld = |elig;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (elig[i]) win = ID_W'(i);
    end

`ifdef PIC_LEVEL_EN
    assign withdraw = ~irq[isr_id];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) pending <= '0;
        else       pending <= irq;
    end
`else
    logic [NSRC-1:0] irq_prev, clr;

    assign withdraw = 1'b0;

    always_comb begin
        clr = '0;
        if (state == REQ && inta) clr[isr_id] = 1'b1;
    end

    // A fresh edge wins over an acknowledge-clear on the same bit.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pending  <= '0;
            irq_prev <= '0;
        end else begin
            pending  <= (pending & ~clr) | (irq & ~irq_prev);
            irq_prev <= irq;
        end
    end
`endif

    always_comb begin
        state_n      = state;
        intr_n       = intr;
        vector_n     = vector;
        isr_id_n     = isr_id;
        in_service_n = in_service;
        case (state)
            IDLE: if (win_vld) begin
                state_n  = REQ;
                intr_n   = 1'b1;
                vector_n = VEC_BASE + VEC_W'(win);
                isr_id_n = win;
            end
            REQ: if (inta) begin
                state_n      = SERVICE;
                intr_n       = 1'b0;
                in_service_n = 1'b1;
            end else if (withdraw) begin
                state_n = IDLE;
                intr_n  = 1'b0;
            end
            SERVICE: if (eoi) begin
                state_n      = IDLE;
                in_service_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            intr       <= 1'b0;
            vector     <= '0;
            isr_id     <= '0;
            in_service <= 1'b0;
            mask       <= '1;
        end else begin
            state      <= state_n;
            intr       <= intr_n;
            vector     <= vector_n;
            isr_id     <= isr_id_n;
            in_service <= in_service_n;
            if (mask_we) mask <= mask_wdata;
        end
    end

endmodule

// File: tb/tb_pic_ctrl.sv
// Self-checking bench for pic_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a request-list reference model.
module tb_pic_ctrl;

    logic       clk = 1'b0, clrn = 1'b0;
    logic [7:0] irq = '0, mask_wdata = '0, mask;
    logic       mask_we = 1'b0, intr, inta = 1'b0, eoi = 1'b0, in_service;
    logic [7:0] vector;
    logic [2:0] isr_id;

    int n_chk = 0, n_pass = 0;

    // reference model state
    bit [7:0] m_pend, m_prev, m_mask, m_vec;
    bit       m_intr, m_svc;
    bit [2:0] m_id;

    pic_ctrl dut (
        .clk(clk), .clrn(clrn), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .mask(mask), .intr(intr), .vector(vector), .inta(inta), .eoi(eoi),
        .in_service(in_service), .isr_id(isr_id)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mask = 8'hFF; m_vec = '0;
        m_intr = 1'b0; m_svc = 1'b0; m_id = '0;
    endtask

    // One clock of the spec's rules, using the inputs present at the edge.
    task automatic model_step();
        bit [7:0] np, elig;
`ifdef PIC_LEVEL_EN
        np = irq;
`else
        np = m_pend;
        if (m_intr && inta) np[m_id] = 1'b0;
        np = np | (irq & ~m_prev);
`endif
        if (m_intr) begin
            if (inta) begin m_intr = 1'b0; m_svc = 1'b1; end
`ifdef PIC_LEVEL_EN
            else if (!irq[m_id]) m_intr = 1'b0;
`endif
        end else if (m_svc) begin
            if (eoi) m_svc = 1'b0;
        end else begin
            elig = m_pend & ~m_mask;
            for (int i = 0; i < 8; i++)
                if (elig[i]) begin
                    m_id = 3'(i); m_intr = 1'b1; m_vec = 8'(8'h50 + i);
                    break;
                end
        end
        m_pend = np;
        m_prev = irq;
        if (mask_we) m_mask = mask_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (intr !== 1'b0 || vector !== 8'h00 || in_service !== 1'b0 || isr_id !== 3'd0 || mask !== 8'hFF)
            $display("FAIL reset intr=%b vec=%h insvc=%b id=%0d mask=%h, want 0/00/0/0/ff",
                     intr, vector, in_service, isr_id, mask);
        else n_pass++;
        @(negedge clk);
        clrn = 1'b1;
        model_reset();
    endtask

    task automatic serve();
        inta = 1'b1; tick(); inta = 1'b0;
        eoi = 1'b1;  tick(); eoi = 1'b0;
    endtask

    task automatic test_basic();
        mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
        irq[5] = 1'b1; tick(); irq[5] = 1'b0;
        n_chk++;
        if (intr !== 1'b0) $display("FAIL t1_early intr=%b want 0", intr); else n_pass++;
        tick();
        n_chk++;
        if (intr !== 1'b1 || vector !== 8'h55) $display("FAIL t1_req intr=%b vec=%h want 1/55", intr, vector);
        else n_pass++;
        inta = 1'b1; tick(); inta = 1'b0;
        n_chk++;
        if (intr !== 1'b0 || in_service !== 1'b1 || isr_id !== 3'd5)
            $display("FAIL t1_ack intr=%b insvc=%b id=%0d want 0/1/5", intr, in_service, isr_id);
        else n_pass++;
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_chk++;
        if (in_service !== 1'b0) $display("FAIL t1_eoi insvc=%b want 0", in_service); else n_pass++;
        tick();
    endtask

    task automatic test_priority();
        irq = 8'h44; tick(); irq = '0; tick();
        n_chk++;
        if (intr !== 1'b1 || vector !== 8'h52) $display("FAIL t2_first intr=%b vec=%h want 1/52", intr, vector);
        else n_pass++;
        serve(); tick();
        n_chk++;
        if (intr !== 1'b1 || vector !== 8'h56) $display("FAIL t2_second intr=%b vec=%h want 1/56", intr, vector);
        else n_pass++;
        serve(); tick();
    endtask

    task automatic test_mask();
        int bad = 0;
        mask_we = 1'b1; mask_wdata = 8'h04; tick(); mask_we = 1'b0;
        irq[2] = 1'b1; tick(); irq[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (intr !== 1'b0) bad++; end
        n_chk++;
        if (bad != 0) $display("FAIL t3_masked intr high in %0d of 20 cycles, want 0", bad); else n_pass++;
        mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
        tick();
        n_chk++;
        if (intr !== 1'b1 || vector !== 8'h52) $display("FAIL t3_unmask intr=%b vec=%h want 1/52", intr, vector);
        else n_pass++;
        serve(); tick();
    endtask

    task automatic test_hold();
        int bad = 0;
        irq[3] = 1'b1; tick(); irq[3] = 1'b0; tick();
        irq[0] = 1'b1; tick(); irq[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (intr !== 1'b1 || vector !== 8'h53) bad++;
            tick();
        end
        n_chk++;
        if (bad != 0) $display("FAIL t4_hold vector/intr changed in %0d cycles, want 53 held", bad); else n_pass++;
        serve(); tick();
        n_chk++;
        if (intr !== 1'b1 || vector !== 8'h50) $display("FAIL t4_next intr=%b vec=%h want 1/50", intr, vector);
        else n_pass++;
        serve(); tick();
    endtask

    task automatic test_async_reset();
        int bad = 0;
        irq[3] = 1'b1; tick(); irq[3] = 1'b0; tick();
        irq[1] = 1'b1;
        #1 clrn = 1'b0;
        #1;
        n_chk++;
        if (intr !== 1'b0 || mask !== 8'hFF || in_service !== 1'b0)
            $display("FAIL t5_reset intr=%b mask=%h insvc=%b want 0/ff/0", intr, mask, in_service);
        else n_pass++;
        clrn = 1'b1;
        model_reset();
        tick(); tick();
        n_chk++;
        if (intr !== 1'b0) $display("FAIL t5_masked intr=%b want 0", intr); else n_pass++;
        mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
        tick();
        n_chk++;
        if (intr !== 1'b1 || vector !== 8'h51) $display("FAIL t5_req intr=%b vec=%h want 1/51", intr, vector);
        else n_pass++;
        irq[1] = 1'b0;
        serve();
        for (int i = 0; i < 5; i++) begin tick(); if (intr !== 1'b0) bad++; end
        n_chk++;
        if (bad != 0) $display("FAIL t5_dropped stale request in %0d cycles, want 0", bad); else n_pass++;
    endtask

    task automatic test_level();
        mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
        irq[4] = 1'b1; tick(); tick();
        n_chk++;
        if (intr !== 1'b1 || vector !== 8'h54) $display("FAIL lv_req intr=%b vec=%h want 1/54", intr, vector);
        else n_pass++;
        serve(); tick();
        n_chk++;
        if (intr !== 1'b1 || vector !== 8'h54) $display("FAIL lv_rereq intr=%b vec=%h want 1/54", intr, vector);
        else n_pass++;
        irq[4] = 1'b0; tick();
        n_chk++;
        if (intr !== 1'b0 || in_service !== 1'b0) $display("FAIL lv_withdraw intr=%b insvc=%b want 0/0", intr, in_service);
        else n_pass++;
        tick(); tick();
        n_chk++;
        if (intr !== 1'b0) $display("FAIL lv_idle intr=%b want 0", intr); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            irq        = 8'($urandom & $urandom & $urandom);
            mask_we    = ($urandom_range(0, 9) == 0);
            mask_wdata = 8'($urandom & $urandom);
            inta       = ($urandom_range(0, 2) == 0);
            eoi        = ($urandom_range(0, 2) == 0);
            tick();
            n_chk++;
            if (intr !== m_intr || in_service !== m_svc || mask !== m_mask || isr_id !== m_id ||
                (m_intr && vector !== m_vec))
                $display("FAIL rand_c%0d intr=%b insvc=%b mask=%h id=%0d vec=%h want %b/%b/%h/%0d/%h",
                         c, intr, in_service, mask, isr_id, vector, m_intr, m_svc, m_mask, m_id, m_vec);
            else n_pass++;
        end
        irq = '0; mask_we = 1'b0; inta = 1'b0; eoi = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
`ifdef PIC_LEVEL_EN
        test_level();
`else
        test_basic();
        test_priority();
        test_mask();
        test_hold();
        test_async_reset();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
